n_alu: RTL and testbench

//   Registered N-bit integer ALU for the single-cycle MIPS datapath.

---
 rtl/n_alu.sv | 105 ++++++++++
 tb/tb_n_alu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/n_alu.sv
// n_alu: registered N-bit integer ALU (shift/add/sub/logic, optional multiply).
// Outputs update one clock after the operands are sampled.
// Optional feature macro: NALU_MUL_EN adds a full-width unsigned multiply on op 1000.
module n_alu #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   op,
    input  logic [N-1:0] nA,
    input  logic [N-1:0] nB,
    output logic [N-1:0] result,
    output logic [N-1:0] resmult,
    output logic         Z,
    output logic         Co
);

    localparam int unsigned SH_W = $clog2(N);

    localparam logic [3:0] OP_SHL  = 4'b0000;
    localparam logic [3:0] OP_SHRL = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SHRA = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
`ifdef NALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1000;
`endif

    logic [SH_W-1:0] sh;
    logic [N:0]      sum_c;
    logic [N:0]      diff_c;
    logic [N-1:0]    res_c;
    logic [N-1:0]    hi_c;
    logic            co_c;
    logic            z_c;
`ifdef NALU_MUL_EN
    logic [2*N-1:0]  prod_c;
`endif

    // Shift amount takes only the low log2(N) bits of nB.
    assign sh = nB[SH_W-1:0];

    // Carry-extended adder and no-borrow subtractor (nA + ~nB + 1).
    assign sum_c  = {1'b0, nA} + {1'b0, nB};
    assign diff_c = {1'b0, nA} + {1'b0, ~nB} + (N+1)'(1);

`ifdef NALU_MUL_EN
    // Full 2N-bit unsigned product.
    assign prod_c = (2*N)'(nA) * (2*N)'(nB);
`endif

    // Next-value selection by opcode; undefined opcodes leave everything zero.
    always_comb begin
        res_c = '0;
        hi_c  = '0;
        co_c  = 1'b0;
        unique case (op)
            OP_SHL:  res_c = nA << sh;
            OP_SHRL: res_c = nA >> sh;
            OP_SHRA: res_c = N'($signed(nA) >>> sh);
            OP_ADD: begin
                res_c = sum_c[N-1:0];
                co_c  = sum_c[N];
            end
            OP_SUB: begin
                res_c = diff_c[N-1:0];
                co_c  = diff_c[N];
            end
            OP_AND:  res_c = nA & nB;
            OP_OR:   res_c = nA | nB;
            OP_XOR:  res_c = nA ^ nB;
`ifdef NALU_MUL_EN
            OP_MUL: begin
                res_c = prod_c[N-1:0];
                hi_c  = prod_c[2*N-1:N];
            end
`endif
            default: begin
                res_c = '0;
                hi_c  = '0;
                co_c  = 1'b0;
            end
        endcase
        z_c = ({hi_c, res_c} == '0);
    end

    // Output register with synchronous reset overriding any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            resmult <= '0;
            Z       <= 1'b1;
            Co      <= 1'b0;
        end else begin
            result  <= res_c;
            resmult <= hi_c;
            Z       <= z_c;
            Co      <= co_c;
        end
    end

endmodule

// File: tb/tb_n_alu.sv
// tb_n_alu: scoreboard bench for n_alu (N=32); expectations queued at drive time.
module tb_n_alu;

    localparam int unsigned N = 32;

    typedef struct packed {
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic         z;
        logic         co;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   op;
    logic [N-1:0] nA;
    logic [N-1:0] nB;
    logic [N-1:0] result;
    logic [N-1:0] resmult;
    logic         Z;
    logic         Co;

    exp_t q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    n_alu #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .nA      (nA),
        .nB      (nB),
        .result  (result),
        .resmult (resmult),
        .Z       (Z),
        .Co      (Co)
    );

    always #5 clk = ~clk;

    // Single comparison point: count and report mismatches.
    task automatic check_val(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        vec_cnt++;
        if (obs !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Independent reference: 64-bit arithmetic, unsigned compare for borrow.
    function automatic exp_t model(input logic [3:0] o, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic r);
        exp_t e;
        logic [63:0] w;
        int unsigned s;
        e = '0;
        s = int'(b[4:0]);
        if (!r) begin
            case (o)
                4'd0: e.res = a << s;
                4'd1: e.res = a >> s;
                4'd3: begin
                    w = {{32{a[31]}}, a} >> s;
                    e.res = w[31:0];
                end
                4'd2: begin
                    w = {32'd0, a} + {32'd0, b};
                    e.res = w[31:0];
                    e.co  = w[32];
                end
                4'd6: begin
                    e.res = a - b;
                    e.co  = (a >= b);
                end
                4'd4: e.res = a & b;
                4'd5: e.res = a | b;
                4'd7: e.res = a ^ b;
`ifdef NALU_MUL_EN
                4'd8: begin
                    w = 64'(a) * 64'(b);
                    e.res = w[31:0];
                    e.hi  = w[63:32];
                end
`endif
                default: e = '0;
            endcase
        end
        e.z = (e.res == '0) && (e.hi == '0);
        return e;
    endfunction

    // Compare the oldest queued expectation against the current outputs.
    task automatic compare_out(input string tag);
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check_val({tag, ".result"},  result,  e.res);
            check_val({tag, ".resmult"}, resmult, e.hi);
            check_val({tag, ".Z"},       N'(Z),   N'(e.z));
            check_val({tag, ".Co"},      N'(Co),  N'(e.co));
        end
    endtask

    // Drive one vector on the falling edge with an explicit expectation.
    task automatic apply_exp(input string tag, input logic r, input logic [3:0] o,
                             input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e);
        @(negedge clk);
        compare_out(tag);
        rst = r;
        op  = o;
        nA  = a;
        nB  = b;
        q.push_back(e);
    endtask

    task automatic apply(input string tag, input logic r, input logic [3:0] o,
                         input logic [N-1:0] a, input logic [N-1:0] b);
        apply_exp(tag, r, o, a, b, model(o, a, b, r));
    endtask

    function automatic exp_t mk(input logic [N-1:0] res, input logic [N-1:0] hi,
                                input logic z, input logic co);
        exp_t e;
        e.res = res;
        e.hi  = hi;
        e.z   = z;
        e.co  = co;
        return e;
    endfunction

    logic [N-1:0] sweep_res [8];
    logic         sweep_z   [8];
    logic         sweep_co  [8];

    initial begin
        rst = 1'b1;
        op  = 4'd0;
        nA  = '0;
        nB  = '0;

        sweep_res = '{32'd2097152, 32'd0, 32'd48, 32'd0, 32'd0, 32'd48, 32'd16, 32'd48};
        sweep_z   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        sweep_co  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset held with live ops.
        apply_exp("rst0", 1'b1, 4'd2, 32'h5, 32'h7, mk('0, '0, 1'b1, 1'b0));
        apply_exp("rst1", 1'b1, 4'd5, 32'hFF, 32'h1, mk('0, '0, 1'b1, 1'b0));

        // Known-value op sweep.
        for (int i = 0; i < 8; i++)
            apply_exp($sformatf("sweep%0d", i), 1'b0, 4'(i), 32'd32, 32'd16,
                      mk(sweep_res[i], '0, sweep_z[i], sweep_co[i]));

        // Carry/borrow boundaries.
        apply_exp("add_wrap", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'h1, mk(32'h0, '0, 1'b1, 1'b1));
        apply_exp("sub_borrow", 1'b0, 4'b0110, 32'h1, 32'h2, mk(32'hFFFF_FFFF, '0, 1'b0, 1'b0));
        apply_exp("sub_eq", 1'b0, 4'b0110, 32'h1234, 32'h1234, mk(32'h0, '0, 1'b1, 1'b1));

        // Shift amount masking and sign fill.
        apply_exp("shra", 1'b0, 4'b0011, 32'h8000_0000, 32'h0000_0024, mk(32'hF800_0000, '0, 1'b0, 1'b0));
        apply_exp("shrl", 1'b0, 4'b0001, 32'h8000_0000, 32'h0000_0024, mk(32'h0800_0000, '0, 1'b0, 1'b0));
        apply_exp("shl0", 1'b0, 4'b0000, 32'hDEAD_BEEF, 32'hFFFF_FFE0, mk(32'hDEAD_BEEF, '0, 1'b0, 1'b0));

        // Multiply opcode with and without the feature.
`ifdef NALU_MUL_EN
        apply_exp("mul", 1'b0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0));
        apply_exp("mul_hi", 1'b0, 4'b1000, 32'h0001_0000, 32'h0001_0000, mk(32'h0, 32'h1, 1'b0, 1'b0));
`else
        apply_exp("mul_off", 1'b0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk('0, '0, 1'b1, 1'b0));
`endif
        apply_exp("undef", 1'b0, 4'b1111, 32'hFFFF_FFFF, 32'h1, mk('0, '0, 1'b1, 1'b0));

        // Reset in the middle of a back-to-back stream, then recovery.
        apply("strm0", 1'b0, 4'b0010, 32'h10, 32'h20);
        apply_exp("strm_rst", 1'b1, 4'b0111, 32'hAAAA_5555, 32'h0F0F_0F0F, mk('0, '0, 1'b1, 1'b0));
        apply_exp("strm1", 1'b0, 4'b0101, 32'hA000_0000, 32'h0000_000B, mk(32'hA000_000B, '0, 1'b0, 1'b0));

        // Random vectors against the reference model.
        for (int i = 0; i < 60; i++)
            apply($sformatf("rnd%0d", i), ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                  $urandom(), $urandom());

        // Drain the last expectation.
        @(negedge clk);
        compare_out("drain");
        if (q.size() != 0) check_val("queue_left", N'(q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
